// File: rtl/mux_lut_array.sv
`default_nettype none
// ============================================================================
// Module      : mux_lut_array
// Description : Array of NUM_CELLS programmable LUT_K-input logic cells. Each
//               cell is a 2:1 mux tree over a truth table plus an optional
//               output register. Tables and register-mode bits are loaded
//               serially into a shadow store, then committed atomically.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_lut_array #(
    parameter int LUT_K     = 2,
    parameter int NUM_CELLS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_start,
    input  logic                         cfg_valid,
    input  logic                         cfg_bit,
    output logic                         cfg_ready,
    output logic                         cfg_done,
    output logic                         active,
    input  logic [NUM_CELLS*LUT_K-1:0]   lut_in,
    output logic [NUM_CELLS-1:0]         lut_out
);

    // Table size per cell, stream bits per cell (table + mode bit), totals.
    localparam int C_T        = 1 << LUT_K;
    localparam int C_CELL_W   = C_T + 1;
    localparam int C_CFG_BITS = NUM_CELLS * C_CELL_W;
    localparam int C_CNT_W    = $clog2(C_CFG_BITS);

    typedef enum logic [1:0] {
        ST_UNCONFIG = 2'd0,
        ST_LOAD     = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [C_CNT_W-1:0]      r_cnt;
    logic [C_CFG_BITS-1:0]   r_shadow;
    logic [C_CFG_BITS-1:0]   r_live;
    logic                    r_active;
    logic [NUM_CELLS-1:0]    r_out;
    logic [NUM_CELLS-1:0]    w_comb;
    logic                    w_accept;
    logic                    w_restart;
    logic                    w_commit;
    logic                    w_last;

    // The final stream position ends the load.
    assign w_last = (r_cnt == C_CNT_W'(C_CFG_BITS - 1));

    // Configuration FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_UNCONFIG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and configuration handshake outputs. A start pulse in
    // LOAD wins over a bit presented in the same cycle, which is dropped.
    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        cfg_done    = 1'b0;
        w_accept    = 1'b0;
        w_restart   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_UNCONFIG: begin
                if (cfg_start) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_start) begin
                    w_restart = 1'b1;
                end else if (cfg_valid) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                cfg_done    = 1'b1;
                w_commit    = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cfg_start) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_UNCONFIG;
            end
        endcase
    end

    // Stream position counter: cleared on (re)start, advances per accepted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_restart) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + C_CNT_W'(1);
        end
    end

    // Shadow store captures accepted stream bits; it is never cleared on restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (w_accept) begin
            r_shadow[r_cnt] <= cfg_bit;
        end
    end

    // Live store and active flag update together on the commit cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live   <= '0;
            r_active <= 1'b0;
        end else if (w_commit) begin
            r_live   <= r_shadow;
            r_active <= 1'b1;
        end
    end

    assign active = r_active;

    // Output registers sample every cell's combinational value; the mode bit
    // chooses which one drives the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_comb;
        end
    end

    for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
        logic [C_T-1:0]   w_tree;
        logic [LUT_K-1:0] w_sel;
        logic             w_reg_en;

        assign w_sel    = lut_in[c*LUT_K +: LUT_K];
        assign w_reg_en = r_live[c*C_CELL_W + C_T];

        // Mux tree folded in place: level l halves the table using select bit l,
        // so input bit 0 steers the leaf level.
        always_comb begin
            w_tree = r_live[c*C_CELL_W +: C_T];
            for (int l = 0; l < LUT_K; l++) begin
                for (int j = 0; j < C_T / 2; j++) begin
                    if (j < (C_T >> (l + 1))) begin
                        w_tree[j] = w_sel[l] ? w_tree[2*j+1] : w_tree[2*j];
                    end
                end
            end
        end

        assign w_comb[c]  = w_tree[0];
        assign lut_out[c] = w_reg_en ? r_out[c] : w_comb[c];
    end

endmodule
`default_nettype wire
